// File: rtl/test_evaluator_pkg.sv
// Shared definitions for the evaluation sequencer, the label memory and the network top.
package test_evaluator_pkg;

  // Default sizing shared with the label memory and the network top
  localparam int unsigned NUM_TESTS_DEFAULT = 750;
  localparam int unsigned LABEL_W_DEFAULT   = 8;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/test_evaluator.sv
// Walks test_sel over 1..NUM_TESTS, launches the classifier once per test and
// scores each prediction against the stored label.
module test_evaluator
  import test_evaluator_pkg::*;
#(
  parameter int unsigned NUM_TESTS = NUM_TESTS_DEFAULT,
  parameter int unsigned LABEL_W   = LABEL_W_DEFAULT,
  parameter int unsigned SEL_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [SEL_W-1:0]   test_sel,
  input  logic [LABEL_W-1:0] label_in,
  output logic               nn_start,
  input  logic               pred_valid,
  input  logic [LABEL_W-1:0] pred_label,
  output logic               busy,
  output logic               done,
  output logic [SEL_W-1:0]   correct_count,
  output logic [SEL_W-1:0]   test_count,
  output logic               last_correct
);

  state_t state, state_nxt;
  logic   hit;
  logic   is_last;

  assign hit      = (pred_label == label_in);
  assign is_last  = (test_sel == SEL_W'(NUM_TESTS));
  assign nn_start = (state == S_ISSUE);
  assign busy     = (state == S_ISSUE) || (state == S_WAIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: one ISSUE cycle per test, then wait for the prediction
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_ISSUE;
      S_ISSUE:        state_nxt = S_WAIT;
      S_WAIT:         if (pred_valid) state_nxt = is_last ? S_DONE : S_ISSUE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Test index, scoring counters and completion flag
  always_ff @(posedge clk) begin
    if (rst) begin
      test_sel      <= SEL_W'(1);
      correct_count <= '0;
      test_count    <= '0;
      last_correct  <= 1'b0;
      done          <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            test_sel      <= SEL_W'(1);
            correct_count <= '0;
            test_count    <= '0;
            last_correct  <= 1'b0;
            done          <= 1'b0;
          end
        end
        S_WAIT: begin
          if (pred_valid) begin
            last_correct  <= hit;
            correct_count <= correct_count + SEL_W'(hit);
            test_count    <= test_count + SEL_W'(1);
            // test_sel stays on the final index so the label memory never sees 0 or NUM_TESTS+1
            if (is_last) done     <= 1'b1;
            else         test_sel <= test_sel + SEL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test_evaluator.sv
// Directed bench for test_evaluator with a cycle-level behavioural model.
module tb_test_evaluator;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst, start, pred_valid;
  logic [31:0] test_sel, correct_count, test_count;
  logic [7:0]  label_in, pred_label;
  logic        nn_start, busy, done, last_correct;

  logic [7:0] labels [1:4];
  logic [7:0] preds  [1:4];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // model: progress of a run described by "run in progress", "launch pending", index and tallies
  bit m_active, m_issue, m_done, m_last;
  int m_sel, m_cc, m_tc;

  int     pulses = 0;
  int     sel_seq[$];

  test_evaluator #(.NUM_TESTS(N), .LABEL_W(8), .SEL_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .test_sel(test_sel), .label_in(label_in),
    .nn_start(nn_start), .pred_valid(pred_valid), .pred_label(pred_label), .busy(busy),
    .done(done), .correct_count(correct_count), .test_count(test_count),
    .last_correct(last_correct)
  );

  always #5 clk = ~clk;

  // label memory: combinational lookup, out-of-range indices read as a poison value
  assign label_in = (test_sel >= 1 && test_sel <= N) ? labels[test_sel] : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of the sequencer
  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_issue = 0; m_done = 0; m_last = 0;
      m_sel = 1; m_cc = 0; m_tc = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_issue = 1; m_done = 0; m_last = 0;
        m_sel = 1; m_cc = 0; m_tc = 0;
      end
    end else if (m_issue) begin
      m_issue = 0;
    end else if (pred_valid) begin
      m_last = (pred_label == labels[m_sel]);
      m_cc   = m_cc + int'(m_last);
      m_tc   = m_tc + 1;
      if (m_sel == N) begin
        m_active = 0; m_done = 1;
      end else begin
        m_sel   = m_sel + 1;
        m_issue = 1;
      end
    end
  end

  // compare every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      check("nn_start", 32'(nn_start), 32'(m_active && m_issue));
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
      check("test_sel", test_sel, m_sel);
      check("correct_count", correct_count, m_cc);
      check("test_count", test_count, m_tc);
      check("last_correct", 32'(last_correct), 32'(m_last));
    end
  end

  // record launches
  always @(negedge clk) begin
    if (nn_start === 1'b1) begin
      pulses++;
      sel_seq.push_back(int'(test_sel));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_nn();
    int t = 0;
    while (nn_start !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    if (nn_start !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL nn_start_timeout: got no pulse within 20 cycles, required 1");
    end
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
    check("kick_nn_start", 32'(nn_start), 1);
    check("kick_test_sel", test_sel, 1);
    check("kick_done", 32'(done), 0);
    check("kick_cc", correct_count, 0);
    check("kick_tc", test_count, 0);
  endtask

  // spur_k: spurious pred_valid in ISSUE; delay_k: prediction 5 cycles late; sw_k: start during WAIT
  task automatic run_tests(input int n, input int spur_k, input int delay_k, input int sw_k);
    int d;
    for (int k = 1; k <= n; k++) begin
      wait_nn();
      if (k == spur_k) begin
        pred_valid = 1'b1;
        pred_label = labels[k] ^ 8'h55;
      end
      step();
      pred_valid = 1'b0;
      d = (k == delay_k) ? 5 : 1;
      if (k == sw_k) begin
        if (d < 2) d = 2;
        start = 1'b1;
      end
      for (int j = 1; j < d; j++) begin
        step();
        start = 1'b0;
      end
      if (d > 1) begin
        check("hold_test_sel", test_sel, k);
        check("hold_busy", 32'(busy), 1);
      end
      pred_valid = 1'b1;
      pred_label = preds[k];
      step();
      pred_valid = 1'b0;
    end
  endtask

  initial begin
    int p0;
    int s0;
    labels[1] = 8'd3; labels[2] = 8'd7; labels[3] = 8'd0; labels[4] = 8'd9;
    rst = 1'b1; start = 1'b0; pred_valid = 1'b0; pred_label = 8'd0;

    // reset
    step();
    chk_en = 1;
    step();
    rst = 1'b0;
    check("rst_test_sel", test_sel, 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cc", correct_count, 0);
    check("rst_tc", test_count, 0);

    // prediction handshake in IDLE is ignored
    pred_valid = 1'b1; pred_label = 8'd3;
    step(); step();
    pred_valid = 1'b0;
    check("idle_pv_tc", test_count, 0);
    check("idle_pv_busy", 32'(busy), 0);

    // short run, mixed results
    preds[1] = 8'd3; preds[2] = 8'd1; preds[3] = 8'd0; preds[4] = 8'd9;
    p0 = pulses; s0 = sel_seq.size();
    kick();
    run_tests(4, 0, 0, 0);
    check("run1_pulses", pulses - p0, 4);
    for (int i = 0; i < 4; i++) check("run1_sel_seq", sel_seq[s0 + i], i + 1);
    check("run1_cc", correct_count, 3);
    check("run1_tc", test_count, 4);
    check("run1_done", 32'(done), 1);
    check("run1_last", 32'(last_correct), 1);
    check("run1_busy", 32'(busy), 0);
    check("run1_sel", test_sel, 4);
    step(); step();
    check("done_hold", 32'(done), 1);
    check("done_hold_cc", correct_count, 3);

    // restart from DONE with spurious, delayed and start-in-WAIT handshakes
    kick();
    run_tests(4, 1, 2, 3);
    check("run2_cc", correct_count, 3);
    check("run2_tc", test_count, 4);
    check("run2_done", 32'(done), 1);

    // reset mid-run after test 2, colliding with start and pred_valid
    preds[1] = 8'd3; preds[2] = 8'd7; preds[3] = 8'd0; preds[4] = 8'd9;
    kick();
    run_tests(2, 0, 0, 0);
    check("mid_tc", test_count, 2);
    rst = 1'b1; start = 1'b1; pred_valid = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; pred_valid = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_nn_start", 32'(nn_start), 0);
    check("midrst_sel", test_sel, 1);
    check("midrst_cc", correct_count, 0);
    check("midrst_tc", test_count, 0);
    check("midrst_done", 32'(done), 0);
    step();
    check("midrst_idle", 32'(busy), 0);
    kick();
    run_tests(4, 0, 0, 0);
    check("run3_cc", correct_count, 4);
    check("run3_tc", test_count, 4);

    // restart from DONE with every prediction wrong
    preds[1] = 8'd4; preds[2] = 8'd8; preds[3] = 8'd1; preds[4] = 8'd10;
    kick();
    run_tests(4, 0, 0, 0);
    check("run4_cc", correct_count, 0);
    check("run4_tc", test_count, 4);
    check("run4_last", 32'(last_correct), 0);
    check("run4_done", 32'(done), 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_evaluator.md
# test_evaluator

Sequencer and scorer on the consuming side of the label memory. It walks `test_sel` from 1 to `NUM_TESTS` and starts the network classifier once per test. For each test it waits for the network's prediction handshake, compares the predicted class with the stored label, and accumulates a correct-prediction count. The block sits between the top-level control (start/done) and the pair of label memory and neural-network core.

## Interface
Parameters:
- `NUM_TESTS`, 750: number of test vectors; `test_sel` spans 1..`NUM_TESTS`.
- `LABEL_W`, 8: width of the label and prediction fields.
- `SEL_W`, 32: width of `test_sel` and of both counters.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin an evaluation run; sampled in IDLE or DONE.
- `test_sel` out `SEL_W`: 1-based test index, driven to the label memory and the image source.
- `label_in` in `LABEL_W`: label for the current `test_sel`, combinational from the label memory.
- `nn_start` out 1: one-cycle pulse telling the network to classify the current `test_sel`.
- `pred_valid` in 1: the network's prediction is present this cycle.
- `pred_label` in `LABEL_W`: predicted class; qualified by `pred_valid`.
- `busy` out 1: a run is in progress.
- `done` out 1: the run has completed; held until the next `start` or `rst`.
- `correct_count` out `SEL_W`: number of predictions equal to the label.
- `test_count` out `SEL_W`: number of tests scored so far.
- `last_correct` out 1: result of the most recent comparison.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE / DONE**, when `start`=1:
  - set `test_sel`←1, `correct_count`←0, `test_count`←0, `last_correct`←0, `done`←0;
  - go to ISSUE.
- **ISSUE:**
  - `nn_start`=1 for exactly this one cycle;
  - go to WAIT unconditionally;
  - a `pred_valid` seen in ISSUE is ignored.
- **WAIT:** stay until `pred_valid`=1. On that edge:
  - `last_correct` ← (`pred_label`==`label_in`);
  - `correct_count` += that bit;
  - `test_count` += 1;
  - if `test_sel`==`NUM_TESTS`, go to DONE with `done`←1 and leave `test_sel` unchanged;
  - otherwise `test_sel` += 1 and go to ISSUE.
- **DONE:** `done`=1 and `busy`=0. The counters hold their final values until `start` or `rst`.
- `busy`=1 exactly in ISSUE and WAIT.
- `start` is ignored in ISSUE and WAIT.
- `pred_valid` is ignored in IDLE, ISSUE and DONE.
- The comparison covers the full `LABEL_W` bits and is unsigned.
- Counters never wrap, because `NUM_TESTS` < 2^`SEL_W`.
- `test_sel` never takes the value 0, so the label memory is never indexed at -1.

## Timing
- Reset values:
  - state IDLE;
  - `test_sel`=1;
  - `nn_start`, `busy`, `done`, `last_correct` = 0;
  - `correct_count`, `test_count` = 0.
- `rst` asserted mid-run returns the block to the reset values on the next edge. It overrides `start` and `pred_valid` arriving in the same cycle.
- `start` at edge N gives ISSUE in cycle N+1, so `nn_start` is high in cycle N+1.
- `label_in` is stable from the cycle after `test_sel` updates. It is therefore valid throughout WAIT.
- Minimum per-test period is 2 cycles (ISSUE, then WAIT with `pred_valid` in its first cycle).
- A run of T tests takes at least 2T cycles from `start` to `done`.
- `done` rises on the edge that scores the last test.
- All outputs are registered, except `nn_start` and `busy`, which are decoded from the state register.

## Structure
- Shared package:
  - FSM state encoding (2-bit localparams IDLE/ISSUE/WAIT/DONE);
  - default `NUM_TESTS` and `LABEL_W` constants, also used by the label memory and the network top.
- Single module with no sub-module. The counters and comparator are too small to justify separate blocks.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `test_sel`=1, all other outputs 0, `busy`=0.
- **Short run, mixed results:** `NUM_TESTS`=4, labels {3,7,0,9}, predictions {3,1,0,9} each returned 1 cycle after `nn_start` → exactly four `nn_start` pulses, `test_sel` sequence 1,2,3,4, `correct_count`=3, `test_count`=4, `done`=1, `last_correct`=1.
- **Spurious and delayed handshakes:** `pred_valid`=1 during ISSUE and in IDLE → no count change; a prediction delayed 5 cycles in WAIT → the state holds and `test_sel` is unchanged until it arrives.
- **`start` while busy:** `start` asserted in WAIT → ignored; the run completes with the normal counts.
- **Reset mid-run:** `rst` after test 2 of 4 → the next cycle shows IDLE, `test_sel`=1, counts 0; a new `start` runs all 4 tests again.
- **Restart from DONE:** `start` in DONE → `done` falls, counts clear, `nn_start` pulses the next cycle with `test_sel`=1; all-wrong predictions give `correct_count`=0 and `test_count`=4.
